id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
// - ID/EX pipeline register with operand forwarding and load-use hazard detection.
// - Captures decoded operands/control from ID; drives ALUop/srcA/srcB of the ALU one cycle later.
// - Also drives store data and control to MEM/WB.
// PARAMETERS
// - DATA_W  16  datapath width (ALU srcA/srcB/ALUresult width)
// - REG_AW  4   register index width; R0 is hardwired zero
// PORTS
// - clk            in   1       rising-edge clock
// - rst            in   1       asynchronous, active-low reset
// - stall          in   1       downstream hold: keep current EX contents
// - flush          in   1       kill: load bubble (branch taken / exception)
// - id_valid       in   1       ID holds a real instruction
// - id_rd1/id_rd2  in   DATA_W  register-file read data
// - id_ra1/id_ra2  in   REG_AW  source register indices
// - id_rd_addr     in   REG_AW  destination register index
// - id_imm         in   DATA_W  sign-extended immediate
// - id_alusrc      in   1       1: srcB = immediate
// - id_aluop       in   2       00 sub, 01 add, 10/11 per ALU
// - id_regwrite/id_memread/id_memwrite  in  1  control bits
// - exmem_regwrite/memwb_regwrite  in  1       forwarding-source write enables
// - exmem_rd/memwb_rd  in  REG_AW  forwarding-source destinations
// - exmem_result/memwb_result  in  DATA_W  forwarding-source data
// - hazard_stall   out  1       load-use: ID/IF must hold this cycle
// - ex_valid       out  1       EX holds a real instruction
// - ALUop          out  2       to ALU
// - srcA/srcB      out  DATA_W  to ALU
// - ex_store_data  out  DATA_W  forwarded rs2 value for stores
// - ex_rd          out  REG_AW  destination index
// - ex_regwrite/ex_memread/ex_memwrite  out  1  registered control
// BEHAVIOUR
// - Reset (rst=0, async): all registers 0.
//   - Outputs: ex_valid=0, ALUop=00, srcA=srcB=ex_store_data=0, ex_rd=0, control=0, hazard_stall=0.
// - Update priority at each posedge: flush > stall > hazard_stall > load.
//   - flush: load bubble, i.e. valid=0, all control=0, all data/index registers=0.
//   - stall (no flush): hold all registers; hazard_stall still evaluated combinationally.
//   - hazard_stall (no flush/stall): load bubble; ID re-presents the same instruction next cycle.
//   - load: capture all id_* inputs; ex_valid <= id_valid.
//     - If id_valid=0, control bits load as 0.
// - Latency: ID inputs appear on EX outputs exactly 1 cycle later.
// - hazard_stall (combinational) = ex_valid & ex_memread & id_valid & ex_rd!=0
//   & (ex_rd==id_ra1 | ex_rd==id_ra2).
// - Operand select:
//   - opA = fwd(rd1_q, ra1_q); opB = fwd(rd2_q, ra2_q).
//   - srcA = opA; srcB = alusrc_q ? imm_q : opB; ex_store_data = opB.
// - Forwarding rules:
//   - Source index 0 is never forwarded.
//   - EX/MEM match takes priority over MEM/WB match; a match requires the source regwrite=1.
// - Width: all data paths DATA_W; no extension or truncation in this block.
// - Reset deasserted mid-operation: first post-reset cycle is a bubble unless ID supplies valid.
// CONFIGURATION
// - ID_EX_FORWARD_EN defined:
//   - Forwarding muxes present as described above.
// - ID_EX_FORWARD_EN undefined:
//   - fwd() returns the registered value; forwarding inputs are ignored.
//   - hazard_stall also asserts on any ex_valid & ex_regwrite dependency (ex_rd!=0 match).
//   - MEM/WB hazards must be covered by compiler NOPs.
// TESTING
// - Reset:
//   - Stimulus: rst=0 with id_valid=1, id_aluop=01.
//   - Response: all outputs 0; after release + 1 clk, ALUop=01, ex_valid=1.
// - Basic load:
//   - Stimulus: id_rd1=5, id_rd2=2, aluop=00, alusrc=0.
//   - Response: next cycle srcA=5, srcB=2, ALUop=00 (ALU yields 3).
// - EX/MEM over MEM/WB priority:
//   - Stimulus: ra1=3; exmem_rd=3, exmem_result=8; memwb_rd=3, memwb_result=9; both regwrite=1.
//   - Response: srcA=8. With exmem_regwrite=0: srcA=9. With ra1=0: srcA=rd1_q.
// - Load-use:
//   - Stimulus: EX holds memread, ex_rd=4; ID ra2=4.
//   - Response: hazard_stall=1; next cycle ex_valid=0, control=0.
//   - Next: instruction loads normally, with memwb forwarding of R4.
// - Stall vs flush:
//   - Stimulus: stall=1 for 3 cycles.
//   - Response: outputs unchanged across all 3 cycles.
//   - Stimulus: stall=1 and flush=1 in the same cycle.
//   - Response: bubble loaded.
// - Immediate path:
//   - Stimulus: alusrc=1, imm=16'hFFFE, rd2=7, memwrite=1.
//   - Response: srcB=16'hFFFE, ex_store_data=7.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with operand forwarding and
// load-use hazard detection.
//
// Captures the decoded instruction from ID on each rising clock edge. The
// captured instruction drives the ALU (ALUop/srcA/srcB), the store data path
// and the MEM/WB control bits during the following cycle.
//
// Update priority at each rising edge: flush > stall > hazard_stall > load.
//   flush        : a bubble is loaded (every register cleared)
//   stall        : everything is held
//   hazard_stall : a bubble is loaded; ID presents the same instruction again
//   load         : every id_* input is captured; control bits are masked
//                  when id_valid=0
//
// Build option: ID_EX_FORWARD_EN
//   defined   : EX/MEM and MEM/WB results are forwarded into the EX operands.
//               A match needs the source's regwrite and a non-zero index.
//               An EX/MEM match wins over a MEM/WB match.
//   undefined : the operands are the registered values and the forwarding
//               inputs are ignored. hazard_stall also fires on any dependency
//               on a register-writing EX instruction. MEM/WB hazards are left
//               to compiler-inserted NOPs.
//
// Ports:
//   clk, rst (async, active-low), stall, flush   clock / reset / pipeline control
//   id_*                                          decoded instruction from ID
//   exmem_*, memwb_*                              forwarding sources
//   hazard_stall                                  load-use: hold ID/IF this cycle
//   ex_valid, ALUop, srcA, srcB                   to the ALU
//   ex_store_data, ex_rd, ex_regwrite,
//   ex_memread, ex_memwrite                       to MEM/WB
module id_ex_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [REG_AW-1:0] id_ra1,
  input  logic [REG_AW-1:0] id_ra2,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alusrc,
  input  logic [1:0]        id_aluop,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              exmem_regwrite,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] srcA,
  output logic [DATA_W-1:0] srcB,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite
);

  typedef struct packed {
    logic              valid;
    logic [1:0]        aluop;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic [REG_AW-1:0] rd;
    logic              alusrc;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
  } ex_t;

  typedef enum logic [1:0] {
    UPD_LOAD,
    UPD_HOLD,
    UPD_BUBBLE
  } upd_e;

  ex_t               ex_q, ex_d;
  upd_e              upd;
  logic              ex_writes_dep;
  logic [DATA_W-1:0] op_a, op_b;

  // Hazard detection
`ifdef ID_EX_FORWARD_EN
  assign ex_writes_dep = ex_q.memread;
`else
  // Without forwarding, any result still in EX is not yet visible to ID.
  assign ex_writes_dep = ex_q.memread | ex_q.regwrite;
`endif

  assign hazard_stall = ex_q.valid & ex_writes_dep & id_valid
                      & (ex_q.rd != '0)
                      & ((ex_q.rd == id_ra1) | (ex_q.rd == id_ra2));

  // Update select
  always_comb begin
    upd = UPD_LOAD;
    if (flush)             upd = UPD_BUBBLE;
    else if (stall)        upd = UPD_HOLD;
    else if (hazard_stall) upd = UPD_BUBBLE;
  end

  always_comb begin
    ex_d = ex_q;
    unique case (upd)
      UPD_BUBBLE: ex_d = '0;
      UPD_HOLD:   ex_d = ex_q;
      default: begin
        ex_d.valid    = id_valid;
        ex_d.aluop    = id_aluop;
        ex_d.rd1      = id_rd1;
        ex_d.rd2      = id_rd2;
        ex_d.imm      = id_imm;
        ex_d.ra1      = id_ra1;
        ex_d.ra2      = id_ra2;
        ex_d.rd       = id_rd_addr;
        ex_d.alusrc   = id_alusrc;
        ex_d.regwrite = id_valid & id_regwrite;
        ex_d.memread  = id_valid & id_memread;
        ex_d.memwrite = id_valid & id_memwrite;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ex_q <= '0;
    else      ex_q <= ex_d;
  end

  // Operand forwarding
`ifdef ID_EX_FORWARD_EN
  always_comb begin
    op_a = ex_q.rd1;
    if (ex_q.ra1 != '0) begin
      if (exmem_regwrite && exmem_rd == ex_q.ra1)      op_a = exmem_result;
      else if (memwb_regwrite && memwb_rd == ex_q.ra1) op_a = memwb_result;
    end
  end

  always_comb begin
    op_b = ex_q.rd2;
    if (ex_q.ra2 != '0) begin
      if (exmem_regwrite && exmem_rd == ex_q.ra2)      op_b = exmem_result;
      else if (memwb_regwrite && memwb_rd == ex_q.ra2) op_b = memwb_result;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
                        exmem_result, memwb_result};
  assign op_a = ex_q.rd1;
  assign op_b = ex_q.rd2;
`endif

  // Outputs
  assign ex_valid      = ex_q.valid;
  assign ALUop         = ex_q.aluop;
  assign srcA          = op_a;
  assign srcB          = ex_q.alusrc ? ex_q.imm : op_b;
  assign ex_store_data = op_b;
  assign ex_rd         = ex_q.rd;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;

endmodule
